// File: rtl/dense_layer_seq_pkg.sv
// Shared encodings, FSM states and arithmetic helpers for the time-multiplexed dense layer.
// Helpers work on 64-bit containers so any BITSIZE up to 31 fits without per-width variants.
package dense_pkg;

    localparam int ACT_IDENTITY = 0;
    localparam int ACT_RELU     = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Sign-magnitude word of 'bits' width to two's complement; -0 naturally maps to 0.
    function automatic logic signed [63:0] sm2tc(input logic [63:0] v, input int bits);
        logic [63:0] mag;
        logic        sgn;
        mag = v & ((64'd1 << (bits - 1)) - 64'd1);
        sgn = |(v & (64'd1 << (bits - 1)));
        if (sgn) begin
            sm2tc = -$signed(mag);
        end else begin
            sm2tc = $signed(mag);
        end
    endfunction

    // Two's complement to sign-magnitude with magnitude saturation; zero is always +0.
    function automatic logic [63:0] tc2sm_sat(input logic signed [63:0] v, input int bits);
        logic [63:0] mag;
        logic [63:0] lim;
        lim = (64'd1 << (bits - 1)) - 64'd1;
        mag = v[63] ? -v : v;
        if (mag > lim) begin
            mag = lim;
        end else begin
            mag = mag;
        end
        if (mag == 64'd0) begin
            tc2sm_sat = 64'd0;
        end else begin
            tc2sm_sat = ({63'd0, v[63]} << (bits - 1)) | mag;
        end
    endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// Handshake and data bundle between a dense layer and its producer/consumer.
interface dense_layer_seq_if #(
    parameter int BITSIZE = 16,
    parameter int N_IN    = 10,
    parameter int N_OUT   = 92
);
    logic                          flush;
    logic                          in_valid;
    logic                          in_ready;
    logic [BITSIZE*N_IN-1:0]       x;
    logic [BITSIZE*N_IN*N_OUT-1:0] w;
    logic [BITSIZE*N_OUT-1:0]      b;
    logic                          out_valid;
    logic                          out_ready;
    logic [BITSIZE*N_OUT-1:0]      y;
    logic                          busy;

    modport slave (
        input  flush, in_valid, x, w, b, out_ready,
        output in_ready, out_valid, y, busy
    );

    modport master (
        output flush, in_valid, x, w, b, out_ready,
        input  in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/dense_layer_seq_mac_lane.sv
// One neuron lane: sign-magnitude multiply, wide two's-complement accumulate,
// then bias add, round-half-away, saturate and optional ReLU during finalise.
module dense_mac_lane
    import dense_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 8,
    parameter int N_IN    = 10,
    parameter int ACT     = ACT_RELU
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               mac_en,
    input  logic               fin_en,
    input  logic [BITSIZE-1:0] x_k,
    input  logic [BITSIZE-1:0] w_k,
    input  logic [BITSIZE-1:0] b_l,
    output logic [BITSIZE-1:0] y_l
);
    localparam int ACC_W = 2 * BITSIZE + clog2(N_IN) + 1;
    localparam int PW    = 2 * BITSIZE;
    localparam int PAD   = 64 - BITSIZE;

    logic signed [63:0]      x_ext_s, w_ext_s, b_ext_s, biased_s, rval_s;
    logic signed [BITSIZE-1:0] x_tc_s, w_tc_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [ACC_W-1:0] acc_r;
    logic [63:0]             mag_s, rmag_s, sm_s;
    logic                    neg_s;

    // Operand conversion and full-width product
    always_comb begin
        x_ext_s = sm2tc({{PAD{1'b0}}, x_k}, BITSIZE);
        w_ext_s = sm2tc({{PAD{1'b0}}, w_k}, BITSIZE);
        x_tc_s  = x_ext_s[BITSIZE-1:0];
        w_tc_s  = w_ext_s[BITSIZE-1:0];
        prod_s  = PW'(x_tc_s) * PW'(w_tc_s);
    end

    // Accumulator, emptied after every finalise and on abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= '0;
        end else if (clr || fin_en) begin
            acc_r <= '0;
        end else if (mac_en) begin
            acc_r <= acc_r + ACC_W'(prod_s);
        end else begin
            acc_r <= acc_r;
        end
    end

    // Finalise: rounding is done on the magnitude so ties move away from zero
    always_comb begin
        b_ext_s  = sm2tc({{PAD{1'b0}}, b_l}, BITSIZE);
        biased_s = 64'(acc_r) + (b_ext_s <<< FRAC);
        neg_s    = biased_s[63];
        mag_s    = neg_s ? -biased_s : biased_s;
        rmag_s   = (mag_s + ((64'd1 << FRAC) >> 1)) >> FRAC;
        rval_s   = neg_s ? -$signed(rmag_s) : $signed(rmag_s);
        sm_s     = tc2sm_sat(rval_s, BITSIZE);
        if ((ACT == ACT_RELU) && sm_s[BITSIZE-1]) begin
            y_l = '0;
        end else begin
            y_l = sm_s[BITSIZE-1:0];
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: LANES neurons per group, N_IN MAC steps per group,
// one finalise cycle per group; result held until the consumer takes it.
module dense_layer_seq
    import dense_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 8,
    parameter int N_IN    = 10,
    parameter int N_OUT   = 92,
    parameter int LANES   = 4,
    parameter int ACT     = ACT_RELU
) (
    input  logic             clk,
    input  logic             reset,
    dense_layer_seq_if.slave io
);
    localparam int G   = (N_OUT + LANES - 1) / LANES;
    localparam int K_W = clog2(N_IN + 1);
    localparam int G_W = clog2(G + 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(N_IN - 1);
    localparam logic [G_W-1:0] G_LAST = G_W'(G - 1);

    state_t                  state_r, state_next_s;
    logic [K_W-1:0]          k_r, k_next_s;
    logic [G_W-1:0]          g_r, g_next_s;
    logic [BITSIZE*N_IN-1:0] x_r;
    logic [BITSIZE*N_OUT-1:0] y_r;
    logic                    out_valid_r, out_valid_next_s, in_ready_r, busy_r;
    logic                    x_load_s, mac_en_s, fin_en_s;
    logic [BITSIZE-1:0]      x_k_s;
    logic [BITSIZE-1:0]      w_k_s [LANES];
    logic [BITSIZE-1:0]      b_l_s [LANES];
    logic [BITSIZE-1:0]      y_l_s [LANES];
    logic [LANES-1:0]        lane_on_s;

    // Next-state logic; flush overrides every state and blocks acceptance
    always_comb begin
        state_next_s     = state_r;
        k_next_s         = k_r;
        g_next_s         = g_r;
        out_valid_next_s = 1'b0;
        x_load_s         = 1'b0;
        mac_en_s         = 1'b0;
        fin_en_s         = 1'b0;
        if (io.flush) begin
            state_next_s = IDLE;
            k_next_s     = '0;
            g_next_s     = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (io.in_valid) begin
                        x_load_s     = 1'b1;
                        k_next_s     = '0;
                        g_next_s     = '0;
                        state_next_s = MAC;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                MAC: begin
                    mac_en_s = 1'b1;
                    if (k_r == K_LAST) begin
                        k_next_s     = '0;
                        state_next_s = FIN;
                    end else begin
                        k_next_s = k_r + {{(K_W-1){1'b0}}, 1'b1};
                    end
                end
                FIN: begin
                    fin_en_s = 1'b1;
                    if (g_r == G_LAST) begin
                        state_next_s = DONE;
                    end else begin
                        g_next_s     = g_r + {{(G_W-1){1'b0}}, 1'b1};
                        state_next_s = MAC;
                    end
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE, so a handshake needs it registered high
                    if (out_valid_r && io.out_ready) begin
                        state_next_s = IDLE;
                    end else begin
                        out_valid_next_s = 1'b1;
                        state_next_s     = DONE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Operand muxing; lanes past N_OUT in the last group see zeros and are not written back
    always_comb begin
        x_k_s = x_r[BITSIZE*int'(k_r) +: BITSIZE];
        for (int l = 0; l < LANES; l++) begin
            if (int'(g_r) * LANES + l < N_OUT) begin
                lane_on_s[l] = 1'b1;
                w_k_s[l] = io.w[BITSIZE*((int'(g_r) * LANES + l) * N_IN + int'(k_r)) +: BITSIZE];
                b_l_s[l] = io.b[BITSIZE*(int'(g_r) * LANES + l) +: BITSIZE];
            end else begin
                lane_on_s[l] = 1'b0;
                w_k_s[l]     = '0;
                b_l_s[l]     = '0;
            end
        end
    end

    // State, counters and registered handshake flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            k_r         <= '0;
            g_r         <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            k_r         <= k_next_s;
            g_r         <= g_next_s;
            out_valid_r <= out_valid_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            busy_r      <= (state_next_s == MAC) || (state_next_s == FIN);
        end
    end

    // Input vector capture on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r <= '0;
        end else if (x_load_s) begin
            x_r <= io.x;
        end else begin
            x_r <= x_r;
        end
    end

    // Result register, written one group at a time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_r <= '0;
        end else if (fin_en_s) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_on_s[l]) begin
                    y_r[BITSIZE*(int'(g_r) * LANES + l) +: BITSIZE] <= y_l_s[l];
                end
            end
        end else begin
            y_r <= y_r;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dense_mac_lane #(
            .BITSIZE(BITSIZE),
            .FRAC   (FRAC),
            .N_IN   (N_IN),
            .ACT    (ACT)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (io.flush),
            .mac_en(mac_en_s),
            .fin_en(fin_en_s),
            .x_k   (x_k_s),
            .w_k   (w_k_s[l]),
            .b_l   (b_l_s[l]),
            .y_l   (y_l_s[l])
        );
    end

    assign io.in_ready  = in_ready_r;
    assign io.out_valid = out_valid_r;
    assign io.busy      = busy_r;
    assign io.y         = y_r;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Self-checking bench: two small layers (identity and ReLU) fed the same vectors, plus a
// default-size layer under random vectors, all checked against an integer reference model.
module tb_dense_layer_seq;
    import dense_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dense_layer_seq_if #(.BITSIZE(16), .N_IN(2),  .N_OUT(3))  ifs ();
    dense_layer_seq_if #(.BITSIZE(16), .N_IN(2),  .N_OUT(3))  ifr ();
    dense_layer_seq_if #(.BITSIZE(16), .N_IN(10), .N_OUT(92)) ifd ();

    assign ifr.flush     = ifs.flush;
    assign ifr.in_valid  = ifs.in_valid;
    assign ifr.x         = ifs.x;
    assign ifr.w         = ifs.w;
    assign ifr.b         = ifs.b;
    assign ifr.out_ready = ifs.out_ready;

    dense_layer_seq #(.BITSIZE(16), .FRAC(8), .N_IN(2), .N_OUT(3), .LANES(2), .ACT(ACT_IDENTITY))
        dut_s (.clk(clk), .reset(reset), .io(ifs));
    dense_layer_seq #(.BITSIZE(16), .FRAC(8), .N_IN(2), .N_OUT(3), .LANES(2), .ACT(ACT_RELU))
        dut_r (.clk(clk), .reset(reset), .io(ifr));
    dense_layer_seq #(.BITSIZE(16), .FRAC(8), .N_IN(10), .N_OUT(92), .LANES(4), .ACT(ACT_RELU))
        dut_d (.clk(clk), .reset(reset), .io(ifd));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sm_val(input logic [15:0] v);
        longint m;
        m = longint'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    // Real-valued neuron in Q.8 integer arithmetic: dot product, bias, round half away, saturate
    function automatic logic [15:0] ref_neuron(input logic [159:0] xv, input logic [14719:0] wv,
                                               input logic [1471:0] bv, input int n_in,
                                               input int o, input bit relu);
        longint s;
        longint m;
        longint r;
        s = sm_val(bv[16*o +: 16]) * 256;
        for (int i = 0; i < n_in; i++) begin
            s += sm_val(xv[16*i +: 16]) * sm_val(wv[16*(o*n_in+i) +: 16]);
        end
        m = (s < 0) ? -s : s;
        r = (m + 128) / 256;
        if (r > 32767) r = 32767;
        if (r == 0) return 16'h0000;
        if (s < 0) return relu ? 16'h0000 : {1'b1, r[14:0]};
        return {1'b0, r[14:0]};
    endfunction

    function automatic logic [15:0] rand_sm();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       v[14:0] = v[14:0] >> 8;
            1:       v[14:0] = v[14:0] >> 4;
            2:       v[14:0] = 15'd0;
            default: v = v;
        endcase
        return v;
    endfunction

    task automatic small_job(input logic [31:0] xv, input logic [95:0] wv, input logic [47:0] bv,
                             input string tag);
        int cyc;
        ifs.x = xv;
        ifs.w = wv;
        ifs.b = bv;
        ifs.in_valid = 1'b1;
        step();
        ifs.in_valid = 1'b0;
        cyc = 0;
        while (ifs.out_valid !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        check_eq({tag, "_lat"}, 64'(cyc), 64'd7);
        check_eq({tag, "_relu_ov"}, 64'(ifr.out_valid), 64'd1);
        for (int o = 0; o < 3; o++) begin
            check_eq($sformatf("%s_id_y%0d", tag, o), 64'(ifs.y[16*o +: 16]),
                     64'(ref_neuron(xv, wv, bv, 2, o, 1'b0)));
            check_eq($sformatf("%s_relu_y%0d", tag, o), 64'(ifr.y[16*o +: 16]),
                     64'(ref_neuron(xv, wv, bv, 2, o, 1'b1)));
        end
    endtask

    task automatic small_drain(input string tag);
        ifs.out_ready = 1'b1;
        step();
        ifs.out_ready = 1'b0;
        check_eq({tag, "_drain_ov"}, 64'(ifs.out_valid), 64'd0);
        check_eq({tag, "_drain_ir"}, 64'(ifs.in_ready), 64'd1);
        check_eq({tag, "_drain_ir_relu"}, 64'(ifr.in_ready), 64'd1);
    endtask

    task automatic default_job(input int idx);
        int cyc;
        for (int i = 0; i < 10; i++) ifd.x[16*i +: 16] = rand_sm();
        for (int i = 0; i < 920; i++) ifd.w[16*i +: 16] = rand_sm();
        for (int i = 0; i < 92; i++) ifd.b[16*i +: 16] = rand_sm();
        ifd.in_valid = 1'b1;
        step();
        ifd.in_valid = 1'b0;
        cyc = 0;
        while (ifd.out_valid !== 1'b1 && cyc < 400) begin
            step();
            cyc++;
        end
        check_eq($sformatf("dflt%0d_lat", idx), 64'(cyc), 64'd254);
        for (int o = 0; o < 92; o++) begin
            check_eq($sformatf("dflt%0d_y%0d", idx, o), 64'(ifd.y[16*o +: 16]),
                     64'(ref_neuron(ifd.x, ifd.w, ifd.b, 10, o, 1'b1)));
        end
        ifd.out_ready = 1'b1;
        step();
        ifd.out_ready = 1'b0;
        check_eq($sformatf("dflt%0d_ir", idx), 64'(ifd.in_ready), 64'd1);
    endtask

    initial begin
        logic [47:0] y_hold;
        logic [95:0] wr;
        n_chk = 0;
        n_fail = 0;
        reset = 1'b0;
        ifs.flush = 1'b0; ifs.in_valid = 1'b0; ifs.out_ready = 1'b0;
        ifs.x = '0; ifs.w = '0; ifs.b = '0;
        ifd.flush = 1'b0; ifd.in_valid = 1'b0; ifd.out_ready = 1'b0;
        ifd.x = '0; ifd.w = '0; ifd.b = '0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_y", 64'(ifs.y), 64'd0);
        check_eq("rst_ov", 64'(ifs.out_valid), 64'd0);
        check_eq("rst_ir", 64'(ifs.in_ready), 64'd1);
        check_eq("rst_busy", 64'(ifs.busy), 64'd0);
        check_eq("rst_dflt_y", 64'(|ifd.y), 64'd0);
        check_eq("rst_dflt_ir", 64'(ifd.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Directed vectors: x0=1.0 x1=2.0; neuron0 -> -1.25, neuron1 -> 3.0, neuron2 -> 1.5625
        small_job({16'h0200, 16'h0100},
                  {16'h0080, 16'h0080, 16'h0100, 16'h0100, 16'h8100, 16'h0080},
                  {16'h0010, 16'h0000, 16'h0040}, "dir");
        check_eq("dir_y0_const", 64'(ifs.y[15:0]), 64'h8140);
        check_eq("dir_relu_y0_const", 64'(ifr.y[15:0]), 64'h0000);
        check_eq("dir_relu_y1_const", 64'(ifr.y[31:16]), 64'h0300);
        check_eq("dir_relu_y2_const", 64'(ifr.y[47:32]), 64'h0190);

        // Backpressure: result held, no new job accepted
        y_hold = ifs.y;
        for (int c = 0; c < 5; c++) begin
            ifs.in_valid = (c == 2) ? 1'b1 : 1'b0;
            step();
            check_eq($sformatf("bp%0d_y", c), 64'(ifs.y), 64'(y_hold));
            check_eq($sformatf("bp%0d_ov", c), 64'(ifs.out_valid), 64'd1);
            check_eq($sformatf("bp%0d_ir", c), 64'(ifs.in_ready), 64'd0);
            check_eq($sformatf("bp%0d_busy", c), 64'(ifs.busy), 64'd0);
        end
        ifs.in_valid = 1'b0;
        small_drain("bp");

        // Saturation and negative-zero handling
        small_job({2{16'h7FFF}}, {6{16'h7FFF}}, 48'd0, "satp");
        check_eq("satp_y0", 64'(ifs.y[15:0]), 64'h7FFF);
        check_eq("satp_y2", 64'(ifs.y[47:32]), 64'h7FFF);
        small_drain("satp");
        small_job({2{16'h7FFF}}, {6{16'hFFFF}}, 48'd0, "satn");
        check_eq("satn_y0", 64'(ifs.y[15:0]), 64'hFFFF);
        check_eq("satn_relu_y0", 64'(ifr.y[15:0]), 64'h0000);
        small_drain("satn");
        for (int i = 0; i < 6; i++) wr[16*i +: 16] = 16'($urandom);
        small_job({2{16'h8000}}, wr, 48'd0, "nz");
        check_eq("nz_y", 64'(ifs.y), 64'd0);
        small_drain("nz");

        // Asynchronous reset in the middle of MAC
        small_job({16'h0300, 16'h0100}, {6{16'h0100}}, {3{16'h0020}}, "pre_rst");
        small_drain("pre_rst");
        ifs.in_valid = 1'b1;
        step();
        ifs.in_valid = 1'b0;
        check_eq("abort_busy", 64'(ifs.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_y", 64'(ifs.y), 64'd0);
        check_eq("abort_ov", 64'(ifs.out_valid), 64'd0);
        check_eq("abort_ir", 64'(ifs.in_ready), 64'd1);
        check_eq("abort_busy0", 64'(ifs.busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Flush mid-MAC: y untouched, next job unaffected by partial sums
        small_job({16'h0180, 16'h8040}, {16'h0100, 16'h8200, 16'h0050, 16'h0300, 16'h80C0, 16'h0011},
                  {16'h8008, 16'h0100, 16'h0004}, "pre_fl");
        small_drain("pre_fl");
        y_hold = ifs.y;
        ifs.x = {16'h7000, 16'h7000};
        ifs.in_valid = 1'b1;
        step();
        ifs.in_valid = 1'b0;
        ifs.flush = 1'b1;
        step();
        ifs.flush = 1'b0;
        check_eq("flush_ir", 64'(ifs.in_ready), 64'd1);
        check_eq("flush_busy", 64'(ifs.busy), 64'd0);
        check_eq("flush_ov", 64'(ifs.out_valid), 64'd0);
        check_eq("flush_y", 64'(ifs.y), 64'(y_hold));
        ifs.flush = 1'b1;
        ifs.in_valid = 1'b1;
        step();
        ifs.flush = 1'b0;
        ifs.in_valid = 1'b0;
        step();
        check_eq("flush_iv_busy", 64'(ifs.busy), 64'd0);
        check_eq("flush_iv_ir", 64'(ifs.in_ready), 64'd1);
        small_job({16'h0100, 16'h0080}, {16'h0040, 16'h8100, 16'h0200, 16'h0100, 16'h0080, 16'h0100},
                  {16'h0000, 16'h8010, 16'h0020}, "post_fl");
        small_drain("post_fl");

        for (int j = 0; j < 20; j++) begin
            logic [31:0] xv;
            logic [95:0] wv;
            logic [47:0] bv;
            for (int i = 0; i < 2; i++) xv[16*i +: 16] = rand_sm();
            for (int i = 0; i < 6; i++) wv[16*i +: 16] = rand_sm();
            for (int i = 0; i < 3; i++) bv[16*i +: 16] = rand_sm();
            small_job(xv, wv, bv, $sformatf("rs%0d", j));
            small_drain($sformatf("rs%0d", j));
        end

        for (int j = 0; j < 200; j++) begin
            default_job(j);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
